// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, variable-latency memory between
// the CPU instruction-fetch port and the data load/store port. Each port gets a
// one-entry result buffer tagged with the request that filled it. Hazard
// outputs stay high until the buffer holds the answer for the current request.
// Data accesses win over fetches because they belong to the older instruction.
// INST_ADDR_WIDTH must equal DATA_ADDR_WIDTH because PC is driven onto mem_addr.
module mem_port_arbiter #(
    parameter int INST_WIDTH      = 32,
    parameter int INST_ADDR_WIDTH = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_ADDR_WIDTH = 32
) (
    input  logic                       cpu_clk,
    input  logic                       cpu_rst_n,
    // instruction fetch port
    input  logic [INST_ADDR_WIDTH-1:0] PC,
    output logic [INST_WIDTH-1:0]      INST,
    output logic                       inst_mem_hazard,
    // data load/store port
    input  logic                       cpu_data_mem_read,
    input  logic [DATA_ADDR_WIDTH-1:0] cpu_data_mem_raddr,
    output logic [DATA_WIDTH-1:0]      data_mem_rdata,
    input  logic                       cpu_data_mem_write,
    input  logic [DATA_ADDR_WIDTH-1:0] cpu_data_mem_waddr,
    input  logic [DATA_WIDTH-1:0]      cpu_data_mem_wdata,
    output logic                       data_mem_hazard,
    // memory side
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [DATA_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]      mem_wdata,
    input  logic                       mem_ack,
    input  logic [DATA_WIDTH-1:0]      mem_rdata
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] INST_BUSY = 2'd1;
    localparam logic [1:0] DATA_BUSY = 2'd2;

    logic [1:0] state;

    // instruction buffer tag
    logic                       inst_valid;
    logic [INST_ADDR_WIDTH-1:0] inst_tag;

    // data buffer tag: the request whose access has completed
    logic                       data_done;
    logic                       data_tag_we;
    logic [DATA_ADDR_WIDTH-1:0] data_tag_addr;
    logic [DATA_WIDTH-1:0]      data_tag_wdata;

    // current data request, normalised so it can be compared against the tag
    logic                       drq;
    logic                       req_we;
    logic [DATA_ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0]      req_wdata;
    logic                       data_tag_match;
    logic                       ack_inst;
    logic                       ack_data;

    // Decode the data request; a simultaneous read and write is treated as a
    // write. Read requests carry zero write data so their tag ignores wdata.
    always_comb begin
        drq       = cpu_data_mem_write | cpu_data_mem_read;
        req_we    = cpu_data_mem_write;
        req_addr  = cpu_data_mem_write ? cpu_data_mem_waddr : cpu_data_mem_raddr;
        req_wdata = cpu_data_mem_write ? cpu_data_mem_wdata : '0;
        data_tag_match = (data_tag_we == req_we) &&
                         (data_tag_addr == req_addr) &&
                         (data_tag_wdata == req_wdata);
        inst_mem_hazard = !(inst_valid && (inst_tag == PC));
        data_mem_hazard = drq && !(data_done && data_tag_match);
        ack_inst = (state == INST_BUSY) && mem_ack;
        ack_data = (state == DATA_BUSY) && mem_ack;
    end

    // Access sequencer. Memory-side outputs are registered and held stable for
    // the whole time mem_req is high. An ack seen in IDLE is ignored.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_mem_hazard) begin
                        state     <= DATA_BUSY;
                        mem_req   <= 1'b1;
                        mem_we    <= req_we;
                        mem_addr  <= req_addr;
                        mem_wdata <= req_wdata;
                    end else if (inst_mem_hazard) begin
                        state    <= INST_BUSY;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= PC;
                    end
                end
                INST_BUSY, DATA_BUSY: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Instruction buffer: fill on fetch completion; invalidate when a store
    // hits the buffered address so the CPU never executes stale code.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            INST       <= '0;
            inst_tag   <= '0;
            inst_valid <= 1'b0;
        end else if (ack_inst) begin
            INST       <= mem_rdata;
            inst_tag   <= mem_addr;
            inst_valid <= 1'b1;
        end else if (ack_data && mem_we && (mem_addr == inst_tag)) begin
            inst_valid <= 1'b0;
        end
    end

    // Data buffer: record the issued request on completion. The result stays
    // claimed until the CPU drops or changes its request; then it is released
    // so a later, different request triggers a fresh access. The tag comes from
    // the issued registers, so an ack coinciding with an input change is still
    // filed under the request that was actually performed.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            data_done      <= 1'b0;
            data_tag_we    <= 1'b0;
            data_tag_addr  <= '0;
            data_tag_wdata <= '0;
            data_mem_rdata <= '0;
        end else if (ack_data) begin
            data_done      <= 1'b1;
            data_tag_we    <= mem_we;
            data_tag_addr  <= mem_addr;
            data_tag_wdata <= mem_wdata;
            if (!mem_we) data_mem_rdata <= mem_rdata;
        end else if (data_done && !(drq && data_tag_match)) begin
            data_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table covering
// reset, fetch and load, followed by hand sequences for the fetch/store
// collision, store/fetch coherence, a long-stalled ack, a spurious ack and a
// reset in the middle of an access. A small memory responder drives mem_ack.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] inst;
    logic        ihaz;
    logic        rd = 1'b0;
    logic [31:0] raddr = '0;
    logic [31:0] rdata;
    logic        wr = 1'b0;
    logic [31:0] waddr = '0;
    logic [31:0] wdata = '0;
    logic        dhaz;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    int n_chk = 0;
    int n_fail = 0;

    // memory responder controls
    int   mem_lat = 1;
    logic hold_ack = 1'b0;
    logic force_ack = 1'b0;
    logic [31:0] mem [0:1023];

    mem_port_arbiter dut (
        .cpu_clk            (clk),
        .cpu_rst_n          (rst_n),
        .PC                 (pc),
        .INST               (inst),
        .inst_mem_hazard    (ihaz),
        .cpu_data_mem_read  (rd),
        .cpu_data_mem_raddr (raddr),
        .data_mem_rdata     (rdata),
        .cpu_data_mem_write (wr),
        .cpu_data_mem_waddr (waddr),
        .cpu_data_mem_wdata (wdata),
        .data_mem_hazard    (dhaz),
        .mem_req            (mem_req),
        .mem_we             (mem_we),
        .mem_addr           (mem_addr),
        .mem_wdata          (mem_wdata),
        .mem_ack            (mem_ack),
        .mem_rdata          (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory responder: acks mem_lat cycles after it first sees mem_req
    // (mem_lat=1 -> ack in the second request cycle). Updates mid-cycle.
    int wait_cnt = 0;
    always begin
        @(negedge clk);
        #2;
        if (!mem_req) begin
            wait_cnt  = 0;
            mem_ack   = force_ack;
            mem_rdata = force_ack ? 32'hBAD0BAD0 : 32'h0;
        end else if (wait_cnt >= mem_lat && !hold_ack) begin
            mem_ack = 1'b1;
            if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
            else        mem_rdata = mem[mem_addr[11:2]];
            wait_cnt = 0;
        end else begin
            mem_ack  = 1'b0;
            wait_cnt = wait_cnt + 1;
        end
    end

    typedef struct {
        logic [31:0] pc;
        logic        rd;
        logic [31:0] raddr;
        int          lat;
        logic        ihaz;
        logic        dhaz;
        logic        req;
        logic [31:0] addr;
        logic [31:0] inst;
        logic [31:0] rdata;
    } vec_t;

    function automatic vec_t mk(logic [31:0] p, logic r, logic [31:0] ra, int l,
                                logic ih, logic dh, logic rq, logic [31:0] a,
                                logic [31:0] in, logic [31:0] rdv);
        vec_t v;
        v.pc = p; v.rd = r; v.raddr = ra; v.lat = l;
        v.ihaz = ih; v.dhaz = dh; v.req = rq; v.addr = a; v.inst = in; v.rdata = rdv;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic haz(string nm, logic ih, logic dh);
        chk({nm, " ihaz"}, {31'b0, ihaz}, {31'b0, ih});
        chk({nm, " dhaz"}, {31'b0, dhaz}, {31'b0, dh});
    endtask

    task automatic memside(string nm, logic rq, logic we, logic [31:0] a);
        chk({nm, " mem_req"}, {31'b0, mem_req}, {31'b0, rq});
        chk({nm, " mem_we"}, {31'b0, mem_we}, {31'b0, we});
        chk({nm, " mem_addr"}, mem_addr, a);
    endtask

    localparam logic [31:0] I0 = 32'h00500093;
    localparam logic [31:0] DB = 32'hDEADBEEF;

    vec_t vecs [18];

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[0]  = I0;
        mem[64] = DB;   // address 0x100

        //            pc  rd raddr   lat ih dh rq addr     inst rdata
        vecs[0]  = mk(0, 0, 0,      1, 1, 0, 0, 0,      0,  0);   // out of reset
        vecs[1]  = mk(0, 0, 0,      1, 1, 0, 1, 0,      0,  0);   // fetch issued
        vecs[2]  = mk(0, 0, 0,      1, 1, 0, 1, 0,      0,  0);   // ack cycle
        vecs[3]  = mk(0, 0, 0,      1, 0, 0, 0, 0,      I0, 0);   // INST valid
        vecs[4]  = mk(0, 1, 'h100,  3, 0, 1, 0, 0,      I0, 0);   // load miss
        vecs[5]  = mk(0, 1, 'h100,  3, 0, 1, 1, 'h100,  I0, 0);
        vecs[6]  = mk(0, 1, 'h100,  3, 0, 1, 1, 'h100,  I0, 0);
        vecs[7]  = mk(0, 1, 'h100,  3, 0, 1, 1, 'h100,  I0, 0);
        vecs[8]  = mk(0, 1, 'h100,  3, 0, 1, 1, 'h100,  I0, 0);   // ack cycle
        vecs[9]  = mk(0, 1, 'h100,  3, 0, 0, 0, 'h100,  I0, DB);  // load done
        vecs[10] = mk(0, 0, 'h100,  3, 0, 0, 0, 'h100,  I0, DB);  // read dropped
        vecs[11] = mk(0, 1, 'h100,  3, 0, 1, 0, 'h100,  I0, DB);  // done released
        vecs[12] = mk(0, 1, 'h100,  3, 0, 1, 1, 'h100,  I0, DB);
        vecs[13] = mk(0, 1, 'h100,  3, 0, 1, 1, 'h100,  I0, DB);
        vecs[14] = mk(0, 1, 'h100,  3, 0, 1, 1, 'h100,  I0, DB);
        vecs[15] = mk(0, 1, 'h100,  3, 0, 1, 1, 'h100,  I0, DB);
        vecs[16] = mk(0, 1, 'h100,  3, 0, 0, 0, 'h100,  I0, DB);
        vecs[17] = mk(0, 0, 'h100,  3, 0, 0, 0, 'h100,  I0, DB);

        // reset, with the initial register state checked during reset
        repeat (3) cyc();
        #1;
        chk("reset mem_req", {31'b0, mem_req}, 32'h0);
        chk("reset ihaz", {31'b0, ihaz}, 32'h1);

        // table: one record per cycle, reset released at the first negedge
        for (int i = 0; i < 18; i++) begin
            cyc();
            if (i == 0) rst_n = 1'b1;
            pc = vecs[i].pc; rd = vecs[i].rd; raddr = vecs[i].raddr; mem_lat = vecs[i].lat;
            #1;
            haz($sformatf("vec%0d", i), vecs[i].ihaz, vecs[i].dhaz);
            chk($sformatf("vec%0d mem_req", i), {31'b0, mem_req}, {31'b0, vecs[i].req});
            chk($sformatf("vec%0d mem_addr", i), mem_addr, vecs[i].addr);
            chk($sformatf("vec%0d INST", i), inst, vecs[i].inst);
            chk($sformatf("vec%0d rdata", i), rdata, vecs[i].rdata);
        end

        // store to 0x40 and fetch miss at 0x40 together: store first, then fetch
        cyc(); pc = 32'h40; wr = 1'b1; waddr = 32'h40; wdata = 32'h12345678; mem_lat = 1; #1;
        haz("col0", 1, 1); memside("col0", 0, 0, 32'h100);
        cyc(); #1; haz("col1", 1, 1); memside("col1", 1, 1, 32'h40);
        chk("col1 mem_wdata", mem_wdata, 32'h12345678);
        cyc(); #1; memside("col2", 1, 1, 32'h40);
        cyc(); #1; haz("col3", 1, 0); memside("col3", 0, 1, 32'h40);
        cyc(); #1; haz("col4", 1, 0); memside("col4", 1, 0, 32'h40);
        cyc(); #1; memside("col5", 1, 0, 32'h40);
        cyc(); #1; haz("col6", 0, 0); chk("col6 INST", inst, 32'h12345678);

        // store hitting the buffered fetch address forces a refetch
        cyc(); wr = 1'b0; #1; haz("coh0", 0, 0);
        cyc(); wr = 1'b1; wdata = 32'hCAFEF00D; #1; haz("coh1", 0, 1);
        cyc(); #1; memside("coh2", 1, 1, 32'h40);
        cyc(); #1; chk("coh3 ihaz", {31'b0, ihaz}, 32'h0);
        cyc(); #1; haz("coh4", 1, 0); chk("coh4 mem_req", {31'b0, mem_req}, 32'h0);
        cyc(); #1; memside("coh5", 1, 0, 32'h40);
        cyc(); #1; chk("coh6 ihaz", {31'b0, ihaz}, 32'h1);
        cyc(); #1; haz("coh7", 0, 0); chk("coh7 INST", inst, 32'hCAFEF00D);

        // stalled ack: request and buffers hold while PC wanders
        cyc(); wr = 1'b0; #1;
        cyc(); wr = 1'b1; waddr = 32'h80; wdata = 32'hA5A5A5A5; hold_ack = 1'b1; #1;
        haz("hold0", 0, 1);
        for (int k = 1; k <= 10; k++) begin
            cyc();
            if (k == 3) pc = 32'h44;
            if (k == 6) pc = 32'h40;
            #1;
            memside($sformatf("hold%0d", k), 1, 1, 32'h80);
            chk($sformatf("hold%0d mem_wdata", k), mem_wdata, 32'hA5A5A5A5);
            haz($sformatf("hold%0d", k), (k >= 3 && k < 6), 1);
            chk($sformatf("hold%0d INST", k), inst, 32'hCAFEF00D);
        end
        hold_ack = 1'b0;
        cyc(); #1; haz("rel", 0, 0); chk("rel mem_req", {31'b0, mem_req}, 32'h0);
        force_ack = 1'b1;
        cyc(); force_ack = 1'b0; #1;
        chk("spur mem_req", {31'b0, mem_req}, 32'h0);
        chk("spur INST", inst, 32'hCAFEF00D);
        chk("spur rdata", rdata, DB);
        haz("spur", 0, 0);
        cyc(); #1; chk("spur2 mem_req", {31'b0, mem_req}, 32'h0);

        // reset in the middle of a data access
        cyc(); wr = 1'b0; #1;
        cyc(); rd = 1'b1; raddr = 32'h100; hold_ack = 1'b1; #1; haz("rst0", 0, 1);
        cyc(); #1; memside("rst1", 1, 0, 32'h100);
        cyc(); #1; chk("rst2 mem_req", {31'b0, mem_req}, 32'h1);
        rst_n = 1'b0; #1;
        chk("rst async mem_req", {31'b0, mem_req}, 32'h0);
        chk("rst mem_addr", mem_addr, 32'h0);
        chk("rst INST", inst, 32'h0);
        chk("rst rdata", rdata, 32'h0);
        haz("rst", 1, 1);
        cyc(); rst_n = 1'b1; hold_ack = 1'b0; rd = 1'b0; pc = 32'h0; mem_lat = 1; #1;
        haz("post0", 1, 0); chk("post0 mem_req", {31'b0, mem_req}, 32'h0);
        cyc(); #1; memside("post1", 1, 0, 32'h0);
        cyc(); #1; chk("post2 ihaz", {31'b0, ihaz}, 32'h1);
        cyc(); #1; haz("post3", 0, 0); chk("post3 INST", inst, I0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency unified memory between the CPU's instruction-fetch port and its data load/store port.
- Sequences each access with a req/ack handshake and buffers the returned word.
- Drives `inst_mem_hazard` / `data_mem_hazard` back to the CPU so its hazard-detection logic stalls the pipeline until the access completes.
- Sits between the `cpu` top and the memory model/controller.

Parameters:
- INST_WIDTH, 32, instruction word width
- INST_ADDR_WIDTH, 32, PC width
- DATA_WIDTH, 32, data/memory word width
- DATA_ADDR_WIDTH, 32, data and memory address width (INST_ADDR_WIDTH must equal DATA_ADDR_WIDTH)

Ports:
- cpu_clk  input  1  single clock, rising edge
- cpu_rst_n  input  1  asynchronous, active-low reset
- PC  input  INST_ADDR_WIDTH  fetch address, requested every cycle
- INST  output  INST_WIDTH  instruction buffer contents
- inst_mem_hazard  output  1  INST not valid for current PC
- cpu_data_mem_read  input  1  load request (MEM stage)
- cpu_data_mem_raddr  input  DATA_ADDR_WIDTH  load address
- data_mem_rdata  output  DATA_WIDTH  load data buffer
- cpu_data_mem_write  input  1  store request (MEM stage)
- cpu_data_mem_waddr  input  DATA_ADDR_WIDTH  store address
- cpu_data_mem_wdata  input  DATA_WIDTH  store data
- data_mem_hazard  output  1  data request pending / not complete
- mem_req  output  1  memory request, held until ack
- mem_we  output  1  1 = write
- mem_addr  output  DATA_ADDR_WIDTH  memory address
- mem_wdata  output  DATA_WIDTH  write data
- mem_ack  input  1  one-cycle completion pulse
- mem_rdata  input  DATA_WIDTH  read data, valid when mem_ack=1

Behaviour:
- Clock and reset: one clock `cpu_clk`; reset `cpu_rst_n` is asynchronous and active-low.
- Reset values:
  - FSM=IDLE; `mem_req`, `mem_we` = 0; `mem_addr`, `mem_wdata` = 0.
  - INST buffer = 0; `data_mem_rdata` buffer = 0.
  - inst_valid = 0; data_done = 0; all tags = 0.
  - Hence `inst_mem_hazard`=1 after reset; `data_mem_hazard` follows its comb equation.
- Data request: drq = `cpu_data_mem_write` | `cpu_data_mem_read`. If both are high, it is a write.
  - Data tag = {op, addr, wdata if write}.
- Combinational outputs:
  - `inst_mem_hazard` = !(inst_valid && inst_tag==PC).
  - `data_mem_hazard` = drq && !(data_done && data_tag==current request).
- FSM states: IDLE, INST_BUSY, DATA_BUSY. All memory-side outputs are registered.
- IDLE:
  - If `data_mem_hazard`: go to DATA_BUSY; load `mem_addr`, `mem_we`, `mem_wdata` from the data port; `mem_req`<=1.
  - Else if `inst_mem_hazard`: go to INST_BUSY; `mem_addr`<=PC, `mem_we`<=0, `mem_req`<=1.
  - Data has priority over fetch because it belongs to the older instruction.
- BUSY states: address and data are held stable while `mem_req`=1.
  - `mem_ack` may arrive in the first `mem_req` cycle or later.
  - On ack: `mem_req`<=0, return to IDLE.
  - INST_BUSY ack: INST<=`mem_rdata`, inst_tag<=`mem_addr`, inst_valid<=1.
  - DATA_BUSY ack: data_done<=1, data_tag<=issued request; on a read, `data_mem_rdata`<=`mem_rdata`.
  - A write ack whose address equals inst_tag clears inst_valid (store/fetch coherence).
- Request consumption: data_done persists until the data request changes (tag mismatch or drq=0), then clears. A new differing request therefore issues a fresh access.
- Buffered outputs stay stable while no ack occurs, even if PC or the request change.
- Latency: a miss detected in cycle N gives `mem_req` high in N+1. Ack in cycle N+k (k≥1) gives hazard low in N+k+1. Minimum 2 stall cycles.
- Simultaneous inst + data miss: data is served first, then fetch. Total stall = both accesses plus one IDLE cycle between them.
- Starvation: fetch cannot starve, because a completed data request holds its result until the pipeline advances, which requires a valid fetch.
- Edge cases:
  - `mem_ack` in IDLE is ignored.
  - Ack in the same cycle that inputs change is still captured into the buffer for the originally issued tag.
  - Reset mid-access aborts the request immediately (`mem_req`→0); memory must tolerate the abandoned request.
  - No address-alignment checks are performed.

Test Plan:
- Reset then PC=0x0, memory word 0x00500093, ack latency 1 → `mem_req` rises cycle 1 with `mem_addr`=0x0; INST=0x00500093 and `inst_mem_hazard`=0 from cycle 3.
- Load raddr=0x100 (mem=0xDEADBEEF) while PC hits, ack latency 3 → `data_mem_hazard`=1 for 5 cycles, then 0 with `data_mem_rdata`=0xDEADBEEF. Drop read → data_done clears.
- Store waddr=0x40, wdata=0x12345678 and PC=0x40 miss in the same cycle → data issued first (`mem_we`=1, `mem_addr`=0x40); fetch of 0x40 follows and returns 0x12345678.
- INST valid for 0x40, then store to 0x40 → inst_valid cleared, `inst_mem_hazard`=1, refetch issued.
- Hold `mem_ack`=0 for 10 cycles → `mem_req`, `mem_addr`, `mem_wdata` constant; hazards held 1. Spurious `mem_ack` in IDLE → no state change.
- Assert `cpu_rst_n`=0 mid DATA_BUSY → `mem_req`=0 asynchronously; after release, the FSM restarts from IDLE with `inst_mem_hazard`=1.
